mem_store_buffer: RTL



---
 rtl/mem_store_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_buffer
// Purpose  : FIFO store buffer ahead of data memory with load forwarding/stall
// Revision : 1.0
// ============================================================================
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     clockg,
  input  logic                     rst,
  input  logic                     halt_sys,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic [AW-1:0]            ld_addr,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_fwd_hit,
  output logic                     ld_stall,
  output logic                     mem_write_en,
  output logic [AW-1:0]            mem_address,
  output logic [DW-1:0]            mem_write_data,
  input  logic [DW-1:0]            mem_data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_ld_inc;
  logic [AW-1:0] w_ld_dec;
  logic          w_overlap;
  logic          w_exact;
  logic [DW-1:0] w_fwd_data;
  logic [PW-1:0] w_idx;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // A same-cycle pop does not make room for a push; ready depends on full only.
  assign w_push  = st_valid && !w_full;
  assign w_pop   = !w_empty && !halt_sys;

  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clockg) begin
    if (w_push && !rst) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end

  // Neighbouring addresses wrap modulo 2^AW so 0xFFFF and 0x0000 overlap.
  assign w_ld_inc = ld_addr + AW'(1);
  assign w_ld_dec = ld_addr - AW'(1);

  // Walk oldest to youngest so the youngest exact match wins.
  always_comb begin
    w_overlap  = 1'b0;
    w_exact    = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if ((r_addr[w_idx] == w_ld_inc) || (r_addr[w_idx] == w_ld_dec))
          w_overlap = 1'b1;
        if (r_addr[w_idx] == ld_addr) begin
          w_exact    = 1'b1;
          w_fwd_data = r_data[w_idx];
        end
      end
    end
  end

  assign mem_write_en   = w_pop;
  assign mem_address    = w_pop ? r_addr[r_head] : ld_addr;
  assign mem_write_data = r_data[r_head];

  // While draining, memory is read at the drain address, so unmatched loads wait.
  assign ld_stall   = w_overlap || (!w_exact && w_pop);
  assign ld_fwd_hit = w_exact && !w_overlap;
  assign ld_data    = ld_fwd_hit ? w_fwd_data : mem_data_out;

  assign st_ready = !w_full;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

endmodule
`default_nettype wire
